joy_serial_multi: RTL and testbench

Parametrised serial joystick reader for shift-register (74HC165-style) controller adapters on the user port. It generalises the fixed two-player DB15 reader to any player count and bits-per-player, and adds a frame-agreement debounce, active-level selection and an enable/idle mode. It runs on the joystick clock domain. Its parallel output feeds the same player-mux logic as the existing DB9/DB15 readers.

---
 rtl/joy_serial_multi.sv | 139 +++++++++++++
 tb/tb_joy_serial_multi.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_multi.sv
// Serial joystick reader for daisy-chained 74HC165-style controller adapters.
// Shifts PLAYERS*BITS bits per frame and applies whole-frame agreement debounce.
module joy_serial_multi #(
    parameter int PLAYERS  = 2,
    parameter int BITS     = 12,
    parameter int CLK_DIV  = 24,
    parameter int DEBOUNCE = 2,
    parameter int INVERT   = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic                    frame_done
);

    localparam int   TOTAL   = PLAYERS * BITS;
    localparam int   IDX_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int   DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int   CNT_W   = $clog2(DEBOUNCE + 1);
    localparam logic INV_BIT = INVERT[0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SAMPLE,
        S_CLOCK,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_armed;
    logic [DIV_W-1:0]   r_div;
    logic [IDX_W-1:0]   r_idx;
    logic [TOTAL-1:0]   r_raw;
    logic [TOTAL-1:0]   r_prev_raw;
    logic [TOTAL-1:0]   r_joy;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_frame_done;
    logic               w_tick;
    logic               w_last;
    logic               w_frame_end;
    logic               w_load;
    logic               w_clk;
    logic [CNT_W-1:0]   w_cnt_new;

    assign w_tick      = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last      = (r_idx == IDX_W'(TOTAL - 1));
    assign w_frame_end = w_tick && (r_state == S_CLOCK) && w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Out of reset the FSM sits in LOAD but keeps joy_load high until the
    // first tick arms it, so the load pulse is always one full tick wide.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b1;
        w_clk        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && en) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_load = !r_armed;
                if (w_tick) begin
                    if (r_armed)  w_state_next = S_SAMPLE;
                    else if (!en) w_state_next = S_IDLE;
                end
            end
            S_SAMPLE: begin
                if (w_tick) w_state_next = S_CLOCK;
            end
            S_CLOCK: begin
                w_clk = 1'b1;
                if (w_tick) w_state_next = w_last ? S_DONE : S_SAMPLE;
            end
            S_DONE: begin
                if (w_tick) w_state_next = en ? S_LOAD : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_new = CNT_W'(1);
        if (r_raw == r_prev_raw) begin
            w_cnt_new = (r_cnt >= CNT_W'(DEBOUNCE)) ? CNT_W'(DEBOUNCE) : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_LOAD;
            r_armed      <= 1'b0;
            r_idx        <= '0;
            r_raw        <= '0;
            r_prev_raw   <= '0;
            r_joy        <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_frame_end;
            if (w_tick) begin
                r_armed <= 1'b1;
                case (r_state)
                    S_LOAD:   r_idx <= '0;
                    S_SAMPLE: r_raw[r_idx] <= joy_data ^ INV_BIT;
                    S_CLOCK:  r_idx <= w_last ? '0 : r_idx + 1'b1;
                    default:  ;
                endcase
            end
            // Debounce lands with frame_done: the last bit was stored one tick earlier.
            if (w_frame_end) begin
                r_prev_raw <= r_raw;
                r_cnt      <= w_cnt_new;
                if (w_cnt_new >= CNT_W'(DEBOUNCE)) r_joy <= r_raw;
            end
        end
    end

    assign joy_load   = w_load;
    assign joy_clk    = w_clk;
    assign joystick   = r_joy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_joy_serial_multi.sv
// Bench for joy_serial_multi: behavioural 74HC165 chain models drive two instances,
// and a frame-history reference model predicts the debounced joystick word.
`timescale 1ns/1ps
module tb_joy_serial_multi;

    localparam int A_DIV = 4;
    localparam int A_DEB = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en_a, en_b;
    logic        jd_a, jc_a, jl_a, fd_a;
    logic [23:0] joy_a;
    logic        jd_b, jc_b, jl_b, fd_b;
    logic [7:0]  joy_b;

    always #5 clk = ~clk;

    joy_serial_multi #(.PLAYERS(2), .BITS(12), .CLK_DIV(A_DIV), .DEBOUNCE(A_DEB), .INVERT(1)) u_a (
        .clk(clk), .reset_n(reset_n), .en(en_a), .joy_data(jd_a),
        .joy_clk(jc_a), .joy_load(jl_a), .joystick(joy_a), .frame_done(fd_a));

    joy_serial_multi #(.PLAYERS(1), .BITS(8), .CLK_DIV(1), .DEBOUNCE(1), .INVERT(0)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .joy_data(jd_b),
        .joy_clk(jc_b), .joy_load(jl_b), .joystick(joy_b), .frame_done(fd_b));

    // Chain A is active-low: pressed buttons (pat_a) appear as zeros on the wire.
    logic [23:0] pat_a;
    logic [23:0] sr_a = '0;
    logic [23:0] loaded_a = '0;
    logic        jc_a_q = 1'b0;
    always @(posedge clk) begin
        if (!jl_a) begin
            sr_a     <= ~pat_a;
            loaded_a <= pat_a;
        end else if (jc_a && !jc_a_q) begin
            sr_a <= sr_a >> 1;
        end
        jc_a_q <= jc_a;
    end
    assign jd_a = sr_a[0];

    logic [7:0] pat_b = 8'b1011_0010;
    logic [7:0] sr_b = '0;
    logic       jc_b_q = 1'b0;
    always @(posedge clk) begin
        if (!jl_b) sr_b <= pat_b;
        else if (jc_b && !jc_b_q) sr_b <= sr_b >> 1;
        jc_b_q <= jc_b;
    end
    assign jd_b = sr_b[0];

    int          errors = 0;
    int          checks = 0;
    logic [23:0] hist[$];
    logic [23:0] exp_a = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output follows a frame only once the last A_DEB captured frames are identical.
    task automatic model_frame(input logic [23:0] c);
        bit agree;
        hist.push_back(c);
        if (hist.size() > A_DEB) void'(hist.pop_front());
        agree = (hist.size() == A_DEB);
        foreach (hist[i]) if (hist[i] != c) agree = 0;
        if (agree) exp_a = c;
    endtask

    task automatic frame_a(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (fd_a !== 1'b1 && n < 600);
        check({tag, "_fd"}, fd_a, 1);
        if (fd_a === 1'b1) begin
            model_frame(loaded_a);
            check(tag, joy_a, exp_a);
        end
    endtask

    task automatic wait_jc(input logic lvl);
        int n = 0;
        while (jc_a !== lvl && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_jc", jc_a, lvl);
    endtask

    task automatic wait_jl(input logic lvl);
        int n = 0;
        while (jl_a !== lvl && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_jl", jl_a, lvl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  bad_load, bad_clk, saw_fd;

        reset_n = 1'b0;
        en_a    = 1'b1;
        en_b    = 1'b1;
        pat_a   = 24'h000ABC;
        repeat (5) @(posedge clk);
        #1;
        check("rst_load", jl_a, 1);
        check("rst_clk", jc_a, 0);
        check("rst_joy", joy_a, 0);
        check("rst_fd", fd_a, 0);
        check("rst_joy_b", joy_b, 0);

        reset_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (jl_a && n < 50);
        check("load_fall", n, A_DIV);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!jl_a && n < 50);
        check("load_width", n, A_DIV);

        n = 0;
        do begin @(posedge clk); #1; n++; end while (fd_b !== 1'b1 && n < 100);
        check("b_fd", fd_b, 1);
        check("b_joy", joy_b, 8'hB2);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (fd_b !== 1'b1 && n < 100);
        check("b_period", n, 18);
        @(posedge clk); #1;
        check("b_fd_width", fd_b, 0);

        // Alternating frames must never agree long enough to update the output.
        for (int i = 0; i < 4; i++) begin
            frame_a("alt", n);
            pat_a = (i % 2 == 0) ? 24'h000555 : 24'h000ABC;
        end
        check("alt_held", joy_a, 0);
        @(posedge clk); #1;
        check("fd_width", fd_a, 0);

        for (int i = 0; i < 3; i++) begin
            frame_a("const_abc", n);
            if (i > 0) check("period", n, 200);
        end
        check("abc_out", joy_a, 24'h000ABC);

        pat_a = 24'h001000;
        for (int i = 0; i < 3; i++) frame_a("map", n);
        check("map_out", joy_a, 24'h001000);

        pat_a = 24'h800001;
        wait_jc(1'b1);
        en_a = 1'b0;
        frame_a("en_drop", n);
        bad_load = 0;
        bad_clk  = 0;
        saw_fd   = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (jl_a !== 1'b1) bad_load = 1;
            if (jc_a !== 1'b0) bad_clk = 1;
            if (fd_a !== 1'b0) saw_fd = 1;
        end
        check("idle_load_low", bad_load, 0);
        check("idle_clk_high", bad_clk, 0);
        check("idle_fd", saw_fd, 0);
        check("idle_joy", joy_a, exp_a);

        en_a = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (jl_a && n < 50);
        check("en_resume", (n >= 1 && n <= A_DIV), 1);
        for (int i = 0; i < 2; i++) frame_a("resume", n);
        check("edge_bits", joy_a, 24'h800001);

        // Async reset during SAMPLE of bit 7, with no clock edge in between.
        wait_jl(1'b0);
        wait_jl(1'b1);
        for (int k = 0; k < 7; k++) begin
            wait_jc(1'b1);
            wait_jc(1'b0);
        end
        @(posedge clk); #1;
        pat_a = 24'hC30F18;
        #1 reset_n = 1'b0;
        #1;
        check("arst_load", jl_a, 1);
        check("arst_clk", jc_a, 0);
        check("arst_joy", joy_a, 0);
        check("arst_fd", fd_a, 0);
        #1 reset_n = 1'b1;
        hist.delete();
        exp_a = '0;
        frame_a("post_rst", n);
        check("post_rst_len", n, 200);
        for (int i = 0; i < 2; i++) frame_a("post_rst", n);
        check("post_rst_out", joy_a, 24'hC30F18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
